// File: rtl/hadamard_sched.sv
// rtl/hadamard_sched.sv - applies a single-qubit Hadamard across a state vector held in single-port RAM
//
// Purpose: for target qubit t, walks every amplitude pair (i0, i0 | 1<<t) with bit t of i0 clear.
//   Each pair is read, passed through the hadamard datapath and written back, 5 cycles per pair.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, target          one-cycle request and target qubit index, sampled in IDLE
//   busy, done, err        status: busy during an operation, done/err one-cycle pulses
//   mem_addr, mem_we,      state-vector RAM interface; read data arrives one cycle
//   mem_wdata, mem_rdata   after an address is presented with mem_we low
// Also holds the fixed-point helpers q_add, q_mul and the combinational hadamard datapath.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef FIXED_FRAC
`define FIXED_FRAC 12
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 4096
`endif
`ifndef FIXED_POINT_CONST_0_7071
`define FIXED_POINT_CONST_0_7071 2896
`endif

// Saturating add/subtract of two signed fixed-point words.
module q_add #(
  parameter int W = `FIXED_WIDTH
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);
  logic [W:0] s;

  always_comb begin
    s = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    // Top two bits disagree only when the W-bit result overflowed.
    if (s[W] != s[W-1]) y = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                y = s[W-1:0];
  end
endmodule

// Saturating fixed-point multiply; the product is floored (arithmetic shift) back to FRAC bits.
module q_mul #(
  parameter int W    = `FIXED_WIDTH,
  parameter int FRAC = `FIXED_FRAC
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  localparam logic signed [2*W-1:0] MAXV = (2*W)'(2**(W-1) - 1);
  localparam logic signed [2*W-1:0] MINV = -MAXV - 1;

  logic signed [2*W-1:0] p;
  logic signed [2*W-1:0] sh;

  always_comb begin
    p  = a * b;
    sh = p >>> FRAC;
    if (sh > MAXV)      y = MAXV[W-1:0];
    else if (sh < MINV) y = MINV[W-1:0];
    else                y = sh[W-1:0];
  end
endmodule

// out_real = (in_real + in_imag) / sqrt2, out_imag = (in_real - in_imag) / sqrt2.
module hadamard #(
  parameter int W = `FIXED_WIDTH
) (
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_imag,
  output logic signed [W-1:0] out_real,
  output logic signed [W-1:0] out_imag
);
  localparam logic signed [W-1:0] C = W'(`FIXED_POINT_CONST_0_7071);

  logic signed [W-1:0] sum;
  logic signed [W-1:0] diff;

  q_add #(.W(W)) u_sum  (.a(in_real), .b(in_imag), .sub(1'b0), .y(sum));
  q_add #(.W(W)) u_diff (.a(in_real), .b(in_imag), .sub(1'b1), .y(diff));
  q_mul #(.W(W)) u_mre  (.a(sum),  .b(C), .y(out_real));
  q_mul #(.W(W)) u_mim  (.a(diff), .b(C), .y(out_imag));
endmodule

module hadamard_sched #(
  parameter int NUM_QUBITS = 3,
  parameter int ADDR_W     = NUM_QUBITS,
  parameter int T_W        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [T_W-1:0]                 target,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_we,
  output logic signed [`FIXED_WIDTH-1:0] mem_wdata,
  input  logic signed [`FIXED_WIDTH-1:0] mem_rdata
);
  localparam logic [T_W-1:0]    NQ     = T_W'(NUM_QUBITS);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(2**(NUM_QUBITS-1) - 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, WR0, WR1, DONE, ERR} state_t;

  state_t                         state;
  logic [ADDR_W-1:0]              k;
  logic [T_W-1:0]                 t;
  logic signed [`FIXED_WIDTH-1:0] a;
  logic signed [`FIXED_WIDTH-1:0] b;
  logic signed [`FIXED_WIDTH-1:0] h_in_imag;
  logic signed [`FIXED_WIDTH-1:0] h_real;
  logic signed [`FIXED_WIDTH-1:0] h_imag;
  logic [ADDR_W-1:0]              i0;
  logic [ADDR_W-1:0]              i1;

  // Insert a zero at bit position tt of kk: bits below tt stay, bits above shift up by one.
  function automatic logic [ADDR_W-1:0] pair_i0(input logic [ADDR_W-1:0] kk,
                                                input logic [T_W-1:0]    tt);
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << tt) - ADDR_W'(1);
    return ((kk & ~mask) << 1) | (kk & mask);
  endfunction

  assign i0 = pair_i0(k, t);
  assign i1 = i0 | (ADDR_W'(1) << t);

  // In CAP the second amplitude is still on mem_rdata; feeding it straight in lets
  // mem_wdata be registered on the way into WR0.
  assign h_in_imag = (state == CAP) ? mem_rdata : b;

  hadamard #(.W(`FIXED_WIDTH)) u_h (
    .in_real (a),
    .in_imag (h_in_imag),
    .out_real(h_real),
    .out_imag(h_imag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      t         <= '0;
      a         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            if (target < NQ) begin
              t        <= target;
              k        <= '0;
              busy     <= 1'b1;
              mem_addr <= pair_i0('0, target);
              state    <= RD0;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        RD0: begin
          mem_addr <= i1;
          state    <= RD1;
        end
        RD1: begin
          a     <= mem_rdata;
          state <= CAP;
        end
        CAP: begin
          b         <= mem_rdata;
          mem_we    <= 1'b1;
          mem_addr  <= i0;
          mem_wdata <= h_real;
          state     <= WR0;
        end
        WR0: begin
          mem_we    <= 1'b1;
          mem_addr  <= i1;
          mem_wdata <= h_imag;
          state     <= WR1;
        end
        WR1: begin
          if (k == LAST_K) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k        <= k + ADDR_W'(1);
            mem_addr <= pair_i0(k + ADDR_W'(1), t);
            state    <= RD0;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hadamard_sched.sv
// tb/tb_hadamard_sched.sv - self-checking bench for hadamard_sched with a 1-cycle-read RAM model

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef FIXED_FRAC
`define FIXED_FRAC 12
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 4096
`endif
`ifndef FIXED_POINT_CONST_0_7071
`define FIXED_POINT_CONST_0_7071 2896
`endif

module tb_hadamard_sched;
  localparam int NQ    = 3;
  localparam int DEPTH = 1 << NQ;
  localparam int S     = `SCALE_FACTOR;
  localparam int C     = `FIXED_POINT_CONST_0_7071;
  localparam int LAT   = 5 * (1 << (NQ - 1)) + 1;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start;
  logic [3:0]                     target;
  logic                           busy;
  logic                           done;
  logic                           err;
  logic [NQ-1:0]                  mem_addr;
  logic                           mem_we;
  logic signed [`FIXED_WIDTH-1:0] mem_wdata;
  logic signed [`FIXED_WIDTH-1:0] mem_rdata;

  logic signed [`FIXED_WIDTH-1:0] mem [DEPTH];
  logic                           ld_en;
  logic [NQ-1:0]                  ld_addr;
  logic signed [`FIXED_WIDTH-1:0] ld_data;
  int                             wr_cnt = 0;
  int                             wr_log [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hadamard_sched #(.NUM_QUBITS(NQ), .ADDR_W(NQ), .T_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_we) begin
      mem[mem_addr]       <= mem_wdata;
      wr_log[wr_cnt % 256] <= int'(mem_addr);
      wr_cnt              <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int init [DEPTH];
    int tgt;
    int expv [DEPTH];
    int tol;
    bit hold;
  } vec_t;

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic int sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  // Reference: (x +/- y) * 0.7071 with saturation and floor, over every index whose bit t is clear.
  function automatic void ref_apply(input int m [DEPTH], input int t, output int r [DEPTH]);
    r = m;
    for (int i = 0; i < DEPTH; i++) begin
      if (((i >> t) & 1) == 0) begin
        int j;
        j = i + (1 << t);
        r[i] = sat((longint'(sat(longint'(m[i]) + m[j])) * C) >>> `FIXED_FRAC);
        r[j] = sat((longint'(sat(longint'(m[i]) - m[j])) * C) >>> `FIXED_FRAC);
      end
    end
  endfunction

  task automatic load_mem(input int v [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = NQ'(i);
      ld_data = `FIXED_WIDTH'(v[i]);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  function automatic void snap(output int v [DEPTH]);
    for (int i = 0; i < DEPTH; i++) v[i] = int'(mem[i]);
  endfunction

  // Issues one start and watches 40 cycles. Cycle n is sampled on the negedge after the n-th
  // rising edge following the accepting edge; busy is expected high for cycles 1..lat.
  task automatic run_op(input int tgt, input bit hold, input int lat,
                        output int done_at, output int done_cnt, output int err_at,
                        output int err_cnt, output int busy_bad);
    done_at = -1; done_cnt = 0; err_at = -1; err_cnt = 0; busy_bad = 0;
    @(negedge clk);
    start  = 1'b1;
    target = 4'(tgt);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
        start = 1'b0;
      end
      if (err) begin
        err_cnt++;
        if (err_at < 0) err_at = n;
      end
      if (busy != (n >= 1 && n <= lat)) busy_bad++;
      if (!hold) start = 1'b0;
    end
    start = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    int got [DEPTH];
    int exp [DEPTH];
    int done_at, done_cnt, err_at, err_cnt, busy_bad, wr_base, order_bad, p;

    vecs[0].init = '{S, 0, 0, 0, 0, 0, 0, 0}; vecs[0].tgt = 0;
    vecs[0].expv = '{C, C, 0, 0, 0, 0, 0, 0}; vecs[0].tol = 2; vecs[0].hold = 0;
    vecs[1].init = '{S, 0, 0, 0, 0, 0, 0, 0}; vecs[1].tgt = 2;
    vecs[1].expv = '{C, 0, 0, 0, C, 0, 0, 0}; vecs[1].tol = 2; vecs[1].hold = 0;
    vecs[2].init = '{C, C, 0, 0, 0, 0, 0, 0}; vecs[2].tgt = 0;
    vecs[2].expv = '{S, 0, 0, 0, 0, 0, 0, 0}; vecs[2].tol = 5; vecs[2].hold = 0;
    vecs[3].init = '{C, -C, 0, 0, 0, 0, 0, 0}; vecs[3].tgt = 0;
    vecs[3].expv = '{0, S, 0, 0, 0, 0, 0, 0}; vecs[3].tol = 2; vecs[3].hold = 1;

    rst = 1'b1; start = 1'b0; target = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  int'(busy), 0, 0);
    check("reset_done",  int'(done), 0, 0);
    check("reset_err",   int'(err), 0, 0);
    check("reset_we",    int'(mem_we), 0, 0);
    check("reset_addr",  int'(mem_addr), 0, 0);
    check("reset_wdata", int'(mem_wdata), 0, 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load_mem(vecs[v].init);
      wr_base = wr_cnt;
      run_op(vecs[v].tgt, vecs[v].hold, LAT, done_at, done_cnt, err_at, err_cnt, busy_bad);
      check($sformatf("v%0d_done_latency", v), done_at, LAT, 0);
      check($sformatf("v%0d_done_count", v), done_cnt, 1, 0);
      check($sformatf("v%0d_busy_window", v), busy_bad, 0, 0);
      check($sformatf("v%0d_write_count", v), wr_cnt - wr_base, DEPTH, 0);
      order_bad = 0;
      p = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (((i >> vecs[v].tgt) & 1) == 0) begin
          if (wr_log[(wr_base + p) % 256] != i) order_bad++;
          if (wr_log[(wr_base + p + 1) % 256] != i + (1 << vecs[v].tgt)) order_bad++;
          p += 2;
        end
      end
      check($sformatf("v%0d_write_order", v), order_bad, 0, 0);
      snap(got);
      for (int i = 0; i < DEPTH; i++)
        check($sformatf("v%0d_mem%0d", v, i), got[i], vecs[v].expv[i], vecs[v].tol);
    end

    // H applied twice on target 1 restores the vector.
    exp = '{S, 0, 0, 0, 0, 0, 0, 0};
    load_mem(exp);
    for (int r = 0; r < 2; r++) begin
      run_op(1, 0, LAT, done_at, done_cnt, err_at, err_cnt, busy_bad);
      check($sformatf("hh%0d_done_latency", r), done_at, LAT, 0);
    end
    snap(got);
    for (int i = 0; i < DEPTH; i++) check($sformatf("hh_mem%0d", i), got[i], exp[i], 5);

    // Out-of-range target is rejected without touching memory.
    exp = '{11, -22, 33, -44, 55, -66, 77, -88};
    load_mem(exp);
    wr_base = wr_cnt;
    run_op(NQ, 0, 0, done_at, done_cnt, err_at, err_cnt, busy_bad);
    check("err_at", err_at, 1, 0);
    check("err_count", err_cnt, 1, 0);
    check("err_no_busy", busy_bad, 0, 0);
    check("err_no_done", done_cnt, 0, 0);
    check("err_no_writes", wr_cnt - wr_base, 0, 0);
    snap(got);
    for (int i = 0; i < DEPTH; i++) check($sformatf("err_mem%0d", i), got[i], exp[i], 0);

    // Reset during WR0 of pair k=1 (cycle 9): WR0's own write lands, nothing after.
    exp = '{S, 0, 0, 0, 0, 0, 0, 0};
    load_mem(exp);
    wr_base = wr_cnt;
    @(negedge clk);
    start = 1'b1; target = 4'd0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_mid_we_in_wr0", int'(mem_we), 1, 0);
    check("rst_mid_addr_in_wr0", int'(mem_addr), 2, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", int'(busy), 0, 0);
    check("rst_mid_we", int'(mem_we), 0, 0);
    check("rst_mid_addr", int'(mem_addr), 0, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_writes", wr_cnt - wr_base, 3, 0);
    snap(got);
    ref_apply(got, 0, exp);
    run_op(0, 0, LAT, done_at, done_cnt, err_at, err_cnt, busy_bad);
    check("post_rst_done_latency", done_at, LAT, 0);
    check("post_rst_busy_window", busy_bad, 0, 0);
    snap(got);
    for (int i = 0; i < DEPTH; i++) check($sformatf("post_rst_mem%0d", i), got[i], exp[i], 0);

    // Randomized vectors against the reference model.
    for (int r = 0; r < 6; r++) begin
      int init [DEPTH];
      int tgt;
      for (int i = 0; i < DEPTH; i++) init[i] = int'($urandom_range(0, 2 * S)) - S;
      tgt = int'($urandom_range(0, NQ - 1));
      load_mem(init);
      ref_apply(init, tgt, exp);
      run_op(tgt, 0, LAT, done_at, done_cnt, err_at, err_cnt, busy_bad);
      check($sformatf("rnd%0d_done_latency", r), done_at, LAT, 0);
      check($sformatf("rnd%0d_busy_window", r), busy_bad, 0, 0);
      snap(got);
      for (int i = 0; i < DEPTH; i++) check($sformatf("rnd%0d_t%0d_mem%0d", r, tgt, i), got[i], exp[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hadamard_sched.md
Name: hadamard_sched

Overview:
- Sequencer that applies the existing combinational hadamard datapath to one target qubit across an N-qubit real-amplitude state vector held in an external single-port memory.
- For each index pair (i0, i1 = i0 | 1<<t), where bit t of i0 is 0:
  - reads both amplitudes,
  - passes them through an internal hadamard instance (in_real = amp[i0], in_imag = amp[i1]),
  - writes out_real back to i0 and out_imag back to i1.
- Sits between the gate-issue controller (start/target/done) and the state-vector RAM.

Parameters:
- NUM_QUBITS, 3, qubit count; state vector depth = 2^NUM_QUBITS.
- ADDR_W, NUM_QUBITS, memory address width.
- T_W, 4, width of target index input; must satisfy 2^T_W > NUM_QUBITS.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to apply H; sampled only in IDLE.
- target  in  T_W  target qubit index; captured when start is accepted.
- busy  out  1  high from cycle after accepted start through DONE state.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse when start is rejected for target >= NUM_QUBITS.
- mem_addr  out  ADDR_W  state-vector address.
- mem_we  out  1  write enable; memory writes at the rising edge while high.
- mem_wdata  out  `FIXED_WIDTH  signed fixed-point write data.
- mem_rdata  in  `FIXED_WIDTH  signed read data; valid the cycle after the address is presented with mem_we = 0 (1-cycle registered read).

Behaviour:
- Reset (rst = 1 at an edge) forces IDLE and clears the pair counter and latches. All outputs are 0 from the next cycle: busy, done, err, mem_we, mem_addr, mem_wdata. Reset mid-operation aborts immediately with no further writes; a partially updated vector is acceptable.
- States: IDLE, RD0, RD1, CAP, WR0, WR1, DONE, ERR.
- IDLE:
  - start & target < NUM_QUBITS: latch t = target, k = 0; go to RD0.
  - start & target >= NUM_QUBITS: go to ERR.
  - Otherwise stay. mem_we = 0.
- Pair address generation:
  - k counts 0 .. 2^(NUM_QUBITS-1) - 1.
  - i0 = k with a 0 bit inserted at position t (low bits below t kept, upper bits shifted left by 1).
  - i1 = i0 | (1 << t).
- RD0: mem_addr = i0, mem_we = 0. Go to RD1.
- RD1: mem_addr = i1, mem_we = 0; latch A = mem_rdata (amp[i0]). Go to CAP.
- CAP: mem_we = 0; latch B = mem_rdata (amp[i1]). Go to WR0.
- WR0: mem_addr = i0, mem_we = 1, mem_wdata = hadamard out_real (A, B). Go to WR1.
- WR1:
  - mem_addr = i1, mem_we = 1, mem_wdata = hadamard out_imag (A, B).
  - If k is the last pair: go to DONE; else k++ and go to RD0.
- DONE: done = 1, busy = 1, mem_we = 0. Go to IDLE.
- ERR: err = 1, busy = 0, no memory access. Go to IDLE.
- Output timing:
  - mem_addr, mem_we, mem_wdata and done/err are decoded from registered state, counter and latches (Moore).
  - busy = (state != IDLE && state != ERR).
  - mem_addr = 0 and mem_wdata = 0 when not driven by an RD/WR state.
- Latency: 5 cycles per pair. For N qubits, done is high exactly 5·2^(N-1) + 1 cycles after the edge that accepts start. N = 3 gives 21.
- start while busy, or in DONE/ERR, is ignored and not queued.
- Arithmetic: width and saturation/rounding are inherited from hadamard, q_add and q_mul. No extra scaling; A and B are stored at full `FIXED_WIDTH.
- t = NUM_QUBITS-1 is valid: i1 = i0 + 2^(N-1). t = 0 pairs adjacent words.
- Memory is never read and written in the same cycle. Each address is written exactly once per operation.

Test Plan:
- Notation: S = `SCALE_FACTOR, C = `FIXED_POINT_CONST_0_7071. Tolerance is ±2 LSB unless stated. Bench memory model has a 1-cycle read.
- N=3, mem = {S,0,0,0,0,0,0,0}, start with target=0 -> mem[0] = C, mem[1] = C, others exactly 0. done pulses once, 21 cycles after the start edge; busy is high for cycles 1–21.
- Same initial mem, target=2 -> mem[0] = C, mem[4] = C, others 0. Write address sequence is 0,4,1,5,2,6,3,7.
- mem[0] = mem[1] = C, target=0 -> mem[0] = S (±5 LSB), mem[1] = 0 (±5 LSB). Then apply H twice on target=1 to {S,0,...} -> mem restored to S at index 0, ±5 LSB.
- mem[0] = C, mem[1] = -C, target=0 -> mem[0] = 0, mem[1] = S. Additionally, start held high for the whole operation -> exactly one done and no second run.
- target=3 with NUM_QUBITS=3 -> err high for one cycle, busy never asserts, mem_we stays 0, memory unchanged.
- rst asserted during the WR0 of pair k=1 -> next cycle busy = 0 and mem_we = 0, no further writes. A following start runs to completion normally.
